gf2_pdiv72x8: RTL and testbench



---
 rtl/gf2_pdiv72x8_if.sv | 46 ++++
 rtl/gf2_pdiv72x8.sv | 160 ++++++++++++++++
 tb/tb_gf2_pdiv72x8.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_pdiv72x8_if.sv
// Handshake/data bundle for gf2_pdiv72x8.
// rem_nz is present only when GF2_PDIV_REM_CHK_EN is defined.
interface gf2_pdiv72x8_if;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] z;
  logic [7:0]  x;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] q;
  logic [6:0]  r;
  logic        dz;
`ifdef GF2_PDIV_REM_CHK_EN
  logic        rem_nz;
`endif

  modport master (
    output in_valid,
    output z,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q,
    input  r,
`ifdef GF2_PDIV_REM_CHK_EN
    input  rem_nz,
`endif
    input  dz
  );

  modport slave (
    input  in_valid,
    input  z,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q,
    output r,
`ifdef GF2_PDIV_REM_CHK_EN
    output rem_nz,
`endif
    output dz
  );
endinterface

// File: rtl/gf2_pdiv72x8.sv
// Sequential GF(2)[x] divider: z = q*x ^ r, deg(r) < deg(x), STEP quotient bits per cycle.
// Optional remainder-nonzero flag enabled by defining GF2_PDIV_REM_CHK_EN.
module gf2_pdiv72x8 #(
  parameter int unsigned STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  gf2_pdiv72x8_if.slave bus
);

  localparam int unsigned NCYC = 72 / STEP;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [6:0]  rem_q, rem_d;
  logic [71:0] sh_q, sh_d;
  logic [7:0]  xn_q, xn_d;
  logic [2:0]  sft_q, sft_d;
  logic        zdiv_q, zdiv_d;
  logic [71:0] q_q, q_d;
  logic [6:0]  r_q, r_d;
  logic        dz_q, dz_d;
`ifdef GF2_PDIV_REM_CHK_EN
  logic        rem_nz_q, rem_nz_d;
`endif

  logic [2:0]  deg;
  logic [2:0]  nsft;
  logic [78:0] zs;
  logic [6:0]  rem_n;
  logic [71:0] sh_n;
  logic [7:0]  t;
  logic        qb;

  always_comb begin : p_deg
    deg = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bus.x[i]) deg = i[2:0];
    end
  end

  // Divisor and dividend are both pre-shifted so the divisor's leading term sits
  // at bit 7: the quotient is unchanged, the remainder comes out scaled by x^sft.
  // This keeps latency fixed at 72/STEP for every divisor degree.
  always_comb begin : p_norm
    nsft = 3'd7 - deg;
    zs   = {7'b0, bus.z} << nsft;
  end

  // sh holds unconsumed dividend bits at the top and quotient bits at the bottom.
  always_comb begin : p_step
    rem_n = rem_q;
    sh_n  = sh_q;
    t     = '0;
    qb    = 1'b0;
    for (int unsigned s = 0; s < STEP; s++) begin
      t  = {rem_n, sh_n[71]};
      qb = t[7];
      if (qb) t = t ^ xn_q;
      rem_n = t[6:0];
      sh_n  = {sh_n[70:0], qb};
    end
  end

  always_comb begin : p_fsm
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    sh_d     = sh_q;
    xn_d     = xn_q;
    sft_d    = sft_q;
    zdiv_d   = zdiv_q;
    q_d      = q_q;
    r_d      = r_q;
    dz_d     = dz_q;
`ifdef GF2_PDIV_REM_CHK_EN
    rem_nz_d = rem_nz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          zdiv_d  = (bus.x == '0);
          sft_d   = nsft;
          xn_d    = bus.x << nsft;
          rem_d   = zs[78:72];
          sh_d    = zs[71:0];
          // A zero divisor still spends one cycle in BUSY to give its one-cycle latency.
          cnt_d   = zdiv_d ? 7'd1 : 7'(NCYC);
        end
      end
      BUSY: begin
        rem_d = rem_n;
        sh_d  = sh_n;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d  = DONE;
          q_d      = zdiv_q ? '0 : sh_n;
          r_d      = zdiv_q ? '0 : (rem_n >> sft_q);
          dz_d     = zdiv_q;
`ifdef GF2_PDIV_REM_CHK_EN
          rem_nz_d = !zdiv_q && (r_d != '0);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      sh_q     <= '0;
      xn_q     <= '0;
      sft_q    <= '0;
      zdiv_q   <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      dz_q     <= 1'b0;
`ifdef GF2_PDIV_REM_CHK_EN
      rem_nz_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      sh_q     <= sh_d;
      xn_q     <= xn_d;
      sft_q    <= sft_d;
      zdiv_q   <= zdiv_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dz_q     <= dz_d;
`ifdef GF2_PDIV_REM_CHK_EN
      rem_nz_q <= rem_nz_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.dz        = dz_q;
`ifdef GF2_PDIV_REM_CHK_EN
  assign bus.rem_nz    = rem_nz_q;
`endif

endmodule

// File: tb/tb_gf2_pdiv72x8.sv
// Bench for gf2_pdiv72x8: four instances (STEP 1,2,4,8) share one stimulus stream;
// expected results go through a scoreboard queue and are checked with immediate assertions.
module tb_gf2_pdiv72x8;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [71:0] z = '0;
  logic [7:0]  x = '0;

  logic [NDUT-1:0] in_ready_v, out_valid_v, dz_v;
  logic [71:0]     q_v [NDUT];
  logic [6:0]      r_v [NDUT];
`ifdef GF2_PDIV_REM_CHK_EN
  logic [NDUT-1:0] rem_nz_v;
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gf2_pdiv72x8_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.z         = z;
    assign bus.x         = x;
    assign bus.out_ready = out_ready;
    gf2_pdiv72x8 #(.STEP(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign dz_v[g]        = bus.dz;
    assign q_v[g]         = bus.q;
    assign r_v[g]         = bus.r;
`ifdef GF2_PDIV_REM_CHK_EN
    assign rem_nz_v[g]    = bus.rem_nz;
`endif
  end

  typedef struct packed {
    logic [71:0] q;
    logic [6:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   lat [NDUT];

  task automatic chk(input string tag, input int g, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, obs, exp);
    end
  endtask

  function automatic logic [71:0] clmul(input logic [63:0] y, input logic [7:0] xx);
    logic [71:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (xx[i]) acc = acc ^ ({8'b0, y} << i);
    return acc;
  endfunction

  task automatic ref_div(input logic [71:0] zz, input logic [7:0] xx,
                         output logic [71:0] qq, output logic [6:0] rr);
    logic [71:0] p;
    int d;
    qq = '0;
    rr = '0;
    if (xx == 8'h00) return;
    d = 0;
    for (int i = 0; i < 8; i++) if (xx[i]) d = i;
    p = zz;
    for (int i = 71; i >= 0; i--) begin
      if (i >= d && p[i]) begin
        qq[i-d] = 1'b1;
        p = p ^ ({64'b0, xx} << (i - d));
      end
    end
    rr = p[6:0];
  endtask

  task automatic push(input logic [71:0] qq, input logic [6:0] rr, input logic dd);
    exp_t e;
    e.q  = qq;
    e.r  = rr;
    e.dz = dd;
    sb.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      chk({tag, "_in_ready"}, g, 72'(in_ready_v[g]), 72'd1);
      chk({tag, "_out_valid"}, g, 72'(out_valid_v[g]), 72'd0);
      chk({tag, "_q"}, g, q_v[g], 72'd0);
      chk({tag, "_r"}, g, 72'(r_v[g]), 72'd0);
      chk({tag, "_dz"}, g, 72'(dz_v[g]), 72'd0);
`ifdef GF2_PDIV_REM_CHK_EN
      chk({tag, "_rem_nz"}, g, 72'(rem_nz_v[g]), 72'd0);
`endif
    end
  endtask

  // One operation through all instances; expectation taken from the scoreboard.
  task automatic do_op(input logic [71:0] zz, input logic [7:0] xx, input bit hold);
    exp_t e;
    int cyc;
    int explat;
    @(posedge clk); #1;
    in_valid = 1'b1;
    z = zz;
    x = xx;
    @(posedge clk); #1;
    in_valid = 1'b0;
    z = {$urandom, $urandom, $urandom};
    x = 8'($urandom);
    chk("in_ready_busy", 0, 72'(in_ready_v), 72'd0);
    for (int g = 0; g < NDUT; g++) lat[g] = -1;
    cyc = 0;
    while (1) begin
      for (int g = 0; g < NDUT; g++) if (lat[g] < 0 && out_valid_v[g]) lat[g] = cyc;
      if ((&out_valid_v) || cyc >= 100) break;
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    for (int g = 0; g < NDUT; g++) begin
      explat = e.dz ? 1 : (72 >> g);
      chk("latency", g, 72'(lat[g]), 72'(explat));
      chk("q", g, q_v[g], e.q);
      chk("r", g, 72'(r_v[g]), 72'(e.r));
      chk("dz", g, 72'(dz_v[g]), 72'(e.dz));
`ifdef GF2_PDIV_REM_CHK_EN
      chk("rem_nz", g, 72'(rem_nz_v[g]), 72'(!e.dz && (e.r != 7'd0)));
`endif
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = k[0];
        z = {$urandom, $urandom, $urandom};
        x = 8'($urandom);
        @(posedge clk); #1;
        chk("hold_out_valid", 0, 72'(out_valid_v), 72'hF);
        chk("hold_in_ready", 0, 72'(in_ready_v), 72'd0);
        for (int g = 0; g < NDUT; g++) begin
          chk("hold_q", g, q_v[g], e.q);
          chk("hold_r", g, 72'(r_v[g]), 72'(e.r));
        end
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("accept_out_valid", 0, 72'(out_valid_v), 72'd0);
    chk("accept_in_ready", 0, 72'(in_ready_v), 72'hF);
  endtask

  initial begin
    logic [71:0] qq;
    logic [6:0]  rr;
    logic [63:0] y;
    logic [71:0] zz;
    logic [7:0]  xx;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    push(72'h02, 7'h01, 1'b0);
    do_op(72'h07, 8'h03, 1'b0);
    push(72'h01_0000_0000_0000_0000, 7'h00, 1'b0);
    do_op(72'h80_0000_0000_0000_0000, 8'h80, 1'b0);
    push(72'hFF_FFFF_FFFF_FFFF_FFFF, 7'h00, 1'b0);
    do_op(72'hFF_FFFF_FFFF_FFFF_FFFF, 8'h01, 1'b0);
    push(72'h00, 7'h00, 1'b1);
    do_op(72'h05, 8'h00, 1'b0);
    push(72'h03, 7'h00, 1'b0);
    do_op(72'h05, 8'h03, 1'b1);

    // Reset during BUSY, about 30 cycles after acceptance.
    @(posedge clk); #1;
    in_valid = 1'b1;
    z = 72'h07;
    x = 8'h03;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("postrst");
    ref_div(72'h1234, 8'h0B, qq, rr);
    push(qq, rr, 1'b0);
    do_op(72'h1234, 8'h0B, 1'b0);

    for (int n = 0; n < 500; n++) begin
      y  = {$urandom, $urandom};
      xx = 8'($urandom_range(1, 255));
      push({8'h00, y}, 7'h00, 1'b0);
      do_op(clmul(y, xx), xx, 1'b0);
    end

    for (int n = 0; n < 200; n++) begin
      zz = {8'($urandom), $urandom, $urandom};
      xx = 8'($urandom_range(1, 255));
      ref_div(zz, xx, qq, rr);
      push(qq, rr, 1'b0);
      do_op(zz, xx, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
